write_buffer: RTL and testbench

//   Write-back side of the cache/memory interface; mirrors the line-return buffer on the read path.

---
 rtl/write_buffer.sv | 182 ++++++++++++++++++
 tb/tb_write_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
// write_buffer
//   Single-line write-back buffer between the D-cache victim path and the AXI bridge.
//   It accepts one dirty line when empty and sends it as one INCR write burst: the
//   AW beat, then BEATS W beats, then it waits for the B response.
//
// Handshake rule used on every channel: a transfer happens on a rising clk edge
// where both valid and ready are high. A valid, once raised, stays high with stable
// payload until that edge. The cache side uses wr_req/wr_rdy the same way, except
// that wr_req may be held while wr_rdy is low and is simply not taken.
//
// Optional feature (macro WRITE_BUFFER_FWD_EN): adds fwd_addr/fwd_hit/fwd_data so
// a read miss to the line being written back can be served from the buffer.
//
// Ports
//   clk, rst             clock (posedge), asynchronous active-high reset
//   wr_req/wr_addr/wr_line/wr_rdy   line intake from the cache
//   awvalid/awready/awaddr/awlen/awsize/awburst   AXI write address channel
//   wvalid/wready/wdata/wstrb/wlast               AXI write data channel
//   bvalid/bready                                 AXI write response channel
//   fwd_addr/fwd_hit/fwd_data                     forwarding lookup (FWD_EN only)
//   dbg_state            current FSM state (0 IDLE, 1 AW, 2 W, 3 B)
module write_buffer #(
  parameter int LINE_WIDTH = 128,
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LINE_WIDTH-1:0] wr_line,
  output logic                  wr_rdy,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [WORD-1:0]       wdata,
  output logic [WORD/8-1:0]     wstrb,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
`ifdef WRITE_BUFFER_FWD_EN
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [WORD-1:0]       fwd_data,
`endif
  output logic [1:0]            dbg_state
);

  localparam int BEATS    = LINE_WIDTH / WORD;
  localparam int OFF      = $clog2(LINE_WIDTH / 8);
  localparam int BYTE_OFF = $clog2(WORD / 8);
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2,
    B    = 2'd3
  } state_e;

  // Word-indexed view of a line: word 0 sits in the low bits.
  typedef logic [BEATS-1:0][WORD-1:0] line_words_t;

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;
  logic                    wr_rdy_q, wr_rdy_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    wlast_q, wlast_d;
  logic                    bready_q, bready_d;
  logic [WORD-1:0]         wdata_q, wdata_d;
  line_words_t             line_words_d;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          addr_d  = {wr_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
          line_d  = wr_line;
          state_d = AW;
        end
      end
      AW: begin
        if (awready) begin
          state_d = W;
          beat_d  = '0;
        end
      end
      W: begin
        if (wready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = B;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      B: begin
        if (bvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state, so each one is valid for the
    // whole cycle of the state it belongs to and holds while stalled.
    line_words_d = line_d;
    wr_rdy_d     = (state_d == IDLE);
    awvalid_d    = (state_d == AW);
    wvalid_d     = (state_d == W);
    bready_d     = (state_d == B);
    wlast_d      = (state_d == W) && (beat_d == LAST_BEAT);
    wdata_d      = line_words_d[beat_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      wr_rdy_q  <= 1'b1;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      wr_rdy_q  <= wr_rdy_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
      wdata_q   <= wdata_d;
    end
  end

  assign wr_rdy    = wr_rdy_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = addr_q;
  assign awlen     = 8'(BEATS - 1);
  assign awsize    = 3'(BYTE_OFF);
  assign awburst   = 2'b01;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = '1;
  assign wlast     = wlast_q;
  assign bready    = bready_q;
  assign dbg_state = state_q;

  // Byte offset inside the line is dropped on capture.
  logic unused_wr_addr_lo;
  assign unused_wr_addr_lo = ^wr_addr[OFF-1:0];

`ifdef WRITE_BUFFER_FWD_EN
  line_words_t line_words_q;
  assign line_words_q = line_q;
  assign fwd_hit  = (state_q != IDLE) &&
                    (fwd_addr[ADDR_WIDTH-1:OFF] == addr_q[ADDR_WIDTH-1:OFF]);
  assign fwd_data = line_words_q[fwd_addr[OFF-1:BYTE_OFF]];

  logic unused_fwd_addr_lo;
  assign unused_fwd_addr_lo = ^fwd_addr[BYTE_OFF-1:0];
`endif

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: randomized line/address stimulus, a negedge bus monitor
// that records every handshake, and feature tasks that compare the recorded bus
// traffic with expectations computed from the line contents.
module tb_write_buffer;

  localparam int BEATS = 4;

  logic         clk;
  logic         rst;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [127:0] wr_line;
  logic         wr_rdy;
  logic         awvalid;
  logic         awready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         wvalid;
  logic         wready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         bvalid;
  logic         bready;
  logic [1:0]   dbg_state;
`ifdef WRITE_BUFFER_FWD_EN
  logic [31:0]  fwd_addr;
  logic         fwd_hit;
  logic [31:0]  fwd_data;
`endif

  write_buffer dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_line(wr_line), .wr_rdy(wr_rdy),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready),
`ifdef WRITE_BUFFER_FWD_EN
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- monitor (records handshakes at negedge) ----------------
  logic [31:0] obs_aw_q[$];
  int          obs_aw_cyc[$];
  logic [31:0] obs_w_q[$];
  bit          obs_wlast_q[$];
  int          obs_w_cyc[$];
  int          b_hs = 0, b_wait_cnt = 0, rdy_in_b = 0;
  int          aw_unstable = 0, w_unstable = 0, w_early = 0;
  int          cyc = 0;
  bit          aw_done = 0, prev_aw_stall = 0, prev_w_stall = 0;
  logic [31:0] prev_awaddr, prev_wdata;
  logic        prev_wlast;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      aw_done = 0; prev_aw_stall = 0; prev_w_stall = 0;
    end else begin
      if (prev_aw_stall && (!awvalid || awaddr !== prev_awaddr)) aw_unstable++;
      if (prev_w_stall && (!wvalid || wdata !== prev_wdata || wlast !== prev_wlast)) w_unstable++;
      if (wvalid && !aw_done) w_early++;
      if (awvalid && awready) begin
        obs_aw_q.push_back(awaddr); obs_aw_cyc.push_back(cyc); aw_done = 1;
      end
      if (wvalid && wready) begin
        obs_w_q.push_back(wdata); obs_wlast_q.push_back(wlast); obs_w_cyc.push_back(cyc);
      end
      if (bready) begin
        if (wr_rdy) rdy_in_b++;
        if (bvalid) begin b_hs++; aw_done = 0; end
        else b_wait_cnt++;
      end
      prev_aw_stall = awvalid && !awready;
      prev_w_stall  = wvalid && !wready;
      prev_awaddr   = awaddr;
      prev_wdata    = wdata;
      prev_wlast    = wlast;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];

  task automatic model_line(input logic [127:0] line);
    exp_q.delete();
    for (int i = 0; i < BEATS; i++) exp_q.push_back(32'(line >> (32 * i)));
  endtask

  task automatic clear_obs();
    obs_aw_q.delete(); obs_aw_cyc.delete();
    obs_w_q.delete(); obs_wlast_q.delete(); obs_w_cyc.delete();
    aw_unstable = 0; w_unstable = 0; w_early = 0; b_wait_cnt = 0; rdy_in_b = 0;
  endtask

  // ---------------- driver ----------------
  // Presents one line, then plays the AXI slave: awready low for aw_stall cycles,
  // wready random or high, bvalid after b_stall cycles of bready. With busy_req
  // set, a second request with other data is held during W/B.
  task automatic do_burst(input logic [31:0] addr, input logic [127:0] line,
                          input int aw_stall, input bit w_rand, input int b_stall,
                          input bit busy_req, output bit ok);
    int b0, n, bw;
    ok = 0; b0 = b_hs; n = 0; bw = 0;
    while (!wr_rdy && n < 50) begin @(posedge clk); #1; n++; end
    wr_req = 1; wr_addr = addr; wr_line = line;
    awready = 0; wready = 0; bvalid = 0;
    @(posedge clk); #1;
    wr_req = 0;
    wr_addr = $urandom;
    wr_line = {$urandom, $urandom, $urandom, $urandom};
    n = 0;
    while (b_hs == b0 && n < 300) begin
      awready = (n >= aw_stall);
      wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bready) begin bvalid = (bw >= b_stall); bw++; end
      else bvalid = 0;
      wr_req = busy_req && !bvalid && (wvalid || bready);
      @(posedge clk); #1; n++;
    end
    awready = 0; wready = 0; bvalid = 0; wr_req = 0;
    ok = (b_hs != b0);
  endtask

  // ---------------- feature tasks ----------------
  task automatic test_reset();
    @(negedge clk);
    n_total++; if (wr_rdy !== 1'b1) $display("FAIL reset_wr_rdy: got %b want 1", wr_rdy); else n_pass++;
    n_total++; if (awvalid !== 1'b0) $display("FAIL reset_awvalid: got %b want 0", awvalid); else n_pass++;
    n_total++; if (wvalid !== 1'b0) $display("FAIL reset_wvalid: got %b want 0", wvalid); else n_pass++;
    n_total++; if (wlast !== 1'b0) $display("FAIL reset_wlast: got %b want 0", wlast); else n_pass++;
    n_total++; if (bready !== 1'b0) $display("FAIL reset_bready: got %b want 0", bready); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_capture();
    bit ok;
    logic [127:0] line = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    clear_obs();
    model_line(line);
    n_total++; if (awlen !== 8'd3) $display("FAIL awlen: got %0d want 3", awlen); else n_pass++;
    n_total++; if (awsize !== 3'b010 || awburst !== 2'b01 || wstrb !== 4'hF)
      $display("FAIL aw_consts: got size %b burst %b strb %h want 010 01 f", awsize, awburst, wstrb);
    else n_pass++;
    do_burst(32'h1C00_003C, line, 0, 0, 0, 0, ok);
    n_total++; if (!ok) $display("FAIL capture_done: got no B handshake want one"); else n_pass++;
    n_total++; if (obs_aw_q.size() != 1 || obs_aw_q[0] !== 32'h1C00_0030)
      $display("FAIL capture_awaddr: got %0d aw, first %h want 1 aw 1c000030", obs_aw_q.size(), obs_aw_q.size() ? obs_aw_q[0] : 32'h0);
    else n_pass++;
    n_total++; if (obs_w_q.size() != BEATS) $display("FAIL capture_beats: got %0d want %0d", obs_w_q.size(), BEATS); else n_pass++;
    for (int i = 0; i < BEATS && i < obs_w_q.size(); i++) begin
      n_total++; if (obs_w_q[i] !== exp_q[i]) $display("FAIL capture_wdata%0d: got %h want %h", i, obs_w_q[i], exp_q[i]); else n_pass++;
      n_total++; if (obs_wlast_q[i] != (i == BEATS - 1)) $display("FAIL capture_wlast%0d: got %b want %b", i, obs_wlast_q[i], i == BEATS - 1); else n_pass++;
    end
    if (obs_w_q.size() == BEATS && obs_aw_cyc.size() == 1) begin
      n_total++; if (obs_w_cyc[0] - obs_aw_cyc[0] != 1 || obs_w_cyc[BEATS-1] - obs_w_cyc[0] != BEATS - 1)
        $display("FAIL capture_latency: got aw->w0 %0d w0->wlast %0d want 1 %0d",
                 obs_w_cyc[0] - obs_aw_cyc[0], obs_w_cyc[BEATS-1] - obs_w_cyc[0], BEATS - 1);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    for (int k = 0; k < 3; k++) begin
      logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
      logic [31:0]  addr = $urandom;
      clear_obs();
      model_line(line);
      do_burst(addr, line, 3, 1, 1, 0, ok);
      n_total++; if (!ok || obs_aw_q.size() != 1 || obs_aw_q[0] !== {addr[31:4], 4'h0})
        $display("FAIL bp_aw%0d: got ok %b n %0d addr %h want 1 1 %h", k, ok, obs_aw_q.size(),
                 obs_aw_q.size() ? obs_aw_q[0] : 32'h0, {addr[31:4], 4'h0});
      else n_pass++;
      n_total++; if (aw_unstable != 0 || w_unstable != 0 || w_early != 0)
        $display("FAIL bp_stable%0d: got aw %0d w %0d early %0d want 0 0 0", k, aw_unstable, w_unstable, w_early);
      else n_pass++;
      n_total++; if (obs_w_q != exp_q) $display("FAIL bp_beats%0d: got %0d beats %p want %p", k, obs_w_q.size(), obs_w_q, exp_q); else n_pass++;
    end
  endtask

  task automatic test_busy_reject();
    bit ok;
    logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
    clear_obs();
    model_line(line);
    do_burst(32'h2000_1234, line, 1, 1, 2, 1, ok);
    n_total++; if (!ok || obs_w_q != exp_q) $display("FAIL busy_beats: got %p want %p", obs_w_q, exp_q); else n_pass++;
    @(negedge clk);
    n_total++; if (wr_rdy !== 1'b1) $display("FAIL busy_rdy: got %b want 1", wr_rdy); else n_pass++;
    @(negedge clk);
    n_total++; if (awvalid !== 1'b0 || obs_aw_q.size() != 1)
      $display("FAIL busy_no_capture: got awvalid %b aw count %0d want 0 1", awvalid, obs_aw_q.size());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_b_wait();
    bit ok;
    logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
    clear_obs();
    do_burst($urandom, line, 0, 0, 5, 0, ok);
    n_total++; if (!ok || b_wait_cnt != 5) $display("FAIL bwait_cycles: got %0d want 5", b_wait_cnt); else n_pass++;
    n_total++; if (rdy_in_b != 0) $display("FAIL bwait_rdy_low: got %0d cycles with wr_rdy want 0", rdy_in_b); else n_pass++;
    @(negedge clk);
    n_total++; if (wr_rdy !== 1'b1 || bready !== 1'b0)
      $display("FAIL bwait_release: got wr_rdy %b bready %b want 1 0", wr_rdy, bready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] all_exp[$];
    all_exp.delete();
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
      model_line(line);
      all_exp = {all_exp, exp_q};
      do_burst($urandom, line, 0, 0, 0, 0, ok);
    end
    n_total++; if (obs_w_q != all_exp) $display("FAIL b2b_beats: got %0d beats want %0d", obs_w_q.size(), all_exp.size()); else n_pass++;
    for (int k = 1; k < obs_aw_cyc.size(); k++) begin
      n_total++; if (obs_aw_cyc[k] - obs_aw_cyc[k-1] < BEATS + 3)
        $display("FAIL b2b_spacing%0d: got %0d want >= %0d", k, obs_aw_cyc[k] - obs_aw_cyc[k-1], BEATS + 3);
      else n_pass++;
    end
  endtask

`ifdef WRITE_BUFFER_FWD_EN
  task automatic test_fwd();
    int n;
    wr_req = 1; wr_addr = 32'h1C00_003C; wr_line = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    awready = 0; wready = 0; bvalid = 0; fwd_addr = 32'h1C00_0038;
    @(posedge clk); #1;
    wr_req = 0;
    @(negedge clk);
    n_total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h3333_3333)
      $display("FAIL fwd_hit: got %b %h want 1 33333333", fwd_hit, fwd_data);
    else n_pass++;
    fwd_addr = 32'h1C00_0040;
    #1;
    n_total++; if (fwd_hit !== 1'b0) $display("FAIL fwd_miss: got %b want 0", fwd_hit); else n_pass++;
    fwd_addr = 32'h1C00_0038;
    @(posedge clk); #1;
    awready = 1; wready = 1; bvalid = 1;
    n = 0;
    while (!wr_rdy && n < 30) begin @(posedge clk); #1; n++; end
    awready = 0; wready = 0; bvalid = 0;
    @(negedge clk);
    n_total++; if (wr_rdy !== 1'b1 || fwd_hit !== 1'b0)
      $display("FAIL fwd_idle: got wr_rdy %b fwd_hit %b want 1 0", wr_rdy, fwd_hit);
    else n_pass++;
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_reset_mid_burst();
    int n;
    clear_obs();
    wr_req = 1; wr_addr = $urandom; wr_line = {$urandom, $urandom, $urandom, $urandom};
    awready = 1; wready = 1;
    @(posedge clk); #1;
    wr_req = 0;
    n = 0;
    while (obs_w_q.size() < 2 && n < 30) begin @(posedge clk); #1; n++; end
    n_total++; if (wvalid !== 1'b1) $display("FAIL rstmid_in_w: got wvalid %b want 1", wvalid); else n_pass++;
    rst = 1;
    @(negedge clk);
    n_total++; if (wvalid !== 1'b0 || wr_rdy !== 1'b1 || awvalid !== 1'b0)
      $display("FAIL rstmid_drop: got wvalid %b wr_rdy %b awvalid %b want 0 1 0", wvalid, wr_rdy, awvalid);
    else n_pass++;
    @(posedge clk); #1;
    rst = 0; awready = 0; wready = 0;
    @(negedge clk);
    n_total++; if (wvalid !== 1'b0 || wr_rdy !== 1'b1)
      $display("FAIL rstmid_after: got wvalid %b wr_rdy %b want 0 1", wvalid, wr_rdy);
    else n_pass++;
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1; wr_req = 0; wr_addr = '0; wr_line = '0;
    awready = 0; wready = 0; bvalid = 0;
`ifdef WRITE_BUFFER_FWD_EN
    fwd_addr = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 0;
    test_reset();
    test_capture();
    test_backpressure();
    test_busy_reject();
    test_b_wait();
    test_back_to_back();
`ifdef WRITE_BUFFER_FWD_EN
    test_fwd();
`endif
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
